eth_tx_framer: RTL and testbench
================================

ETH_TX_FRAMER -- requirements
Module: eth_tx_framer

Interface
REQ-001 SHALL have parameter MTU, default 1536, the maximum payload byte count accepted.
REQ-002 SHALL have parameter IFG, default 12, the number of idle inter-frame-gap cycles after each frame.
REQ-003 clk  input  1  system clock; every register updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  one-cycle request to transmit the frame held in the TX buffer.
REQ-006 len  input  16  payload byte count, sampled only in the cycle start is accepted.
REQ-007 busy  output  1  high from the cycle after an accepted start until done.
REQ-008 done  output  1  one-cycle pulse when the frame and its IFG are complete.
REQ-009 err  output  1  one-cycle pulse, coincident with done, when a start is rejected.
REQ-010 buf_addr  output  16  read address into the TX byte buffer.
REQ-011 buf_data  input  8  buffer read data, valid one clk after buf_addr (synchronous RAM).
REQ-012 txd  output  8  byte-wide (GMII-style) transmit data, one byte per clk.
REQ-013 tx_en  output  1  high while txd carries a frame byte.

Function
REQ-014 SHALL use the states IDLE, PRE, SFD, DATA, PAD, FCS, GAP and RESP.
REQ-015 IDLE: start=1 with 1<=len<=MTU SHALL latch len, clear the byte counter, and go to PRE.
REQ-016 IDLE: start=1 with len=0 or len>MTU SHALL go to RESP without driving tx_en; in RESP, done=1 and err=1 for one cycle, then IDLE.
REQ-017 start outside IDLE SHALL be ignored, with no effect on the frame in progress.
REQ-018 PRE SHALL drive txd=0x55 with tx_en=1 for exactly 7 cycles, then go to SFD.
REQ-019 SFD SHALL drive txd=0xD5 with tx_en=1 for 1 cycle.
REQ-020 SFD SHALL present buf_addr=0 so that byte 0 is on buf_data in the first DATA cycle.
REQ-021 DATA SHALL output buffer bytes 0..len-1 in order, one per cycle, issuing buf_addr one cycle ahead.
REQ-022 After DATA, if len<60, PAD SHALL drive txd=0x00 for 60-len cycles.
REQ-023 With the FCS compiled in, FCS SHALL then drive the 4 FCS bytes.
REQ-024 The FCS SHALL be CRC-32 with reflected polynomial 0xEDB88320 and init 0xFFFFFFFF, computed over data and pad bytes.
REQ-025 The FCS SHALL be transmitted as the final complement, least-significant byte first.
REQ-026 GAP SHALL hold tx_en=0 and txd=0x00 for IFG cycles, then go to RESP.
REQ-027 RESP after a sent frame SHALL pulse done=1 with err=0 and return to IDLE; busy SHALL be 0 in that next IDLE cycle.
REQ-028 Latency: start accepted at edge T SHALL give the first preamble byte at T+1.
REQ-029 tx_en SHALL stay high for exactly 8+max(len,60)+F contiguous cycles, where F=4 with the FCS compiled in and F=0 without it.
REQ-030 len=MTU SHALL read addresses 0..MTU-1 only; buf_addr SHALL never exceed MTU-1.
REQ-031 A new start SHALL be accepted in the IDLE cycle immediately following done (back-to-back frames).

Reset
REQ-032 rst_n=0 SHALL force IDLE asynchronously.
REQ-033 Reset values SHALL be busy=0, done=0, err=0, tx_en=0, txd=0x00, buf_addr=0, CRC register=0xFFFFFFFF.
REQ-034 Reset asserted mid-frame SHALL drop tx_en in the same cycle; no done SHALL be generated for the aborted frame.

Configuration
REQ-035 Macro ETH_TX_FCS_EN SHALL control whether the CRC generator is compiled in.
REQ-036 With ETH_TX_FCS_EN defined, the CRC generator and FCS state SHALL be present and the 4 FCS bytes SHALL be appended.
REQ-037 With ETH_TX_FCS_EN undefined, there SHALL be no CRC logic and the FCS state SHALL be skipped (PAD/DATA goes to GAP); padding to 60 bytes SHALL be unchanged.

Verification
REQ-038 len=64, buffer[i]=i, FCS on -> txd sequence 7x0x55, 0xD5, 0x00..0x3F, 4 FCS bytes; tx_en high 76 cycles; done 13 cycles after tx_en falls.
REQ-039 len=14, FCS on -> 14 data bytes then 46 bytes of 0x00; tx_en high 72 cycles; the receiver-side CRC over data+FCS equals residue 0xDEBB20E3.
REQ-040 len=0 and len=MTU+1 -> tx_en stays 0, done=err=1 one cycle after start, busy never asserted.
REQ-041 start pulsed again during DATA -> ignored; a single frame is output; a start in the cycle after done begins a second frame at the next edge.
REQ-042 rst_n low during DATA byte 20 -> tx_en=0 immediately, no done; a later start with len=60 gives a correct 72-cycle frame.
REQ-043 ETH_TX_FCS_EN undefined, len=60 -> tx_en high 68 cycles and the last byte equals buffer[59].

Source files
------------

// File: rtl/eth_tx_framer_if.sv
// Host-side bundle of the Ethernet TX framer: frame request/response
// handshake, TX buffer read port and the GMII-style byte stream.
interface eth_tx_framer_if;
    logic        start;
    logic [15:0] len;
    logic        busy;
    logic        done;
    logic        err;
    logic [15:0] buf_addr;
    logic [7:0]  buf_data;
    logic [7:0]  txd;
    logic        tx_en;

    modport master (
        output start, len, buf_data,
        input  busy, done, err, buf_addr, txd, tx_en
    );

    modport slave (
        input  start, len, buf_data,
        output busy, done, err, buf_addr, txd, tx_en
    );
endinterface

// File: rtl/eth_tx_framer.sv
// Ethernet TX framer: preamble, SFD, payload from a sync-read buffer, zero pad
// to 60 bytes, optional CRC-32 FCS (macro ETH_TX_FCS_EN), then inter-frame gap.
module eth_tx_framer #(
    parameter int MTU = 1536,
    parameter int IFG = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    eth_tx_framer_if.slave   bus,
    output logic [2:0]       dbg_state
);

    // Handshake: start is a one-cycle request honoured only in IDLE; busy covers
    // the whole frame; done pulses once at the end (with err when rejected).
    typedef enum logic [2:0] {
        S_IDLE, S_PRE, S_SFD, S_DATA, S_PAD, S_FCS, S_GAP, S_RESP
    } state_t;

`ifdef ETH_TX_FCS_EN
    localparam state_t S_TAIL = S_FCS;
`else
    localparam state_t S_TAIL = S_GAP;
`endif

    state_t      state_q, state_d;
    logic [15:0] cnt_q;
    logic [15:0] len_q;
    logic        err_q;
    logic        len_ok;
    logic        accept;
    logic        reject;

    assign len_ok    = (bus.len != 16'd0) && (bus.len <= 16'(MTU));
    assign accept    = (state_q == S_IDLE) && bus.start && len_ok;
    assign reject    = (state_q == S_IDLE) && bus.start && !len_ok;
    assign dbg_state = state_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= 16'd0;
            len_q   <= 16'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept)
                len_q <= bus.len;
            if (state_q == S_IDLE)
                err_q <= reject;
            // The byte counter runs on from DATA into PAD so PAD ends at byte 59.
            if ((state_d == S_IDLE) || ((state_d != state_q) && (state_d != S_PAD)))
                cnt_q <= 16'd0;
            else
                cnt_q <= cnt_q + 16'd1;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept)
                    state_d = S_PRE;
                else if (reject)
                    state_d = S_RESP;
            end
            S_PRE:  if (cnt_q == 16'd6) state_d = S_SFD;
            S_SFD:  state_d = S_DATA;
            S_DATA: begin
                if (cnt_q == len_q - 16'd1)
                    state_d = (len_q < 16'd60) ? S_PAD : S_TAIL;
            end
            S_PAD:  if (cnt_q == 16'd59) state_d = S_TAIL;
`ifdef ETH_TX_FCS_EN
            S_FCS:  if (cnt_q == 16'd3) state_d = S_GAP;
`endif
            S_GAP:  if (cnt_q == 16'(IFG - 1)) state_d = S_RESP;
            S_RESP: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

`ifdef ETH_TX_FCS_EN
    logic [31:0] crc_q;
    logic [31:0] fcs;

    function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c ^ {24'd0, b};
        for (int i = 0; i < 8; i++)
            r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        return r;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            crc_q <= 32'hFFFFFFFF;
        else if (accept)
            crc_q <= 32'hFFFFFFFF;
        else if ((state_q == S_DATA) || (state_q == S_PAD))
            crc_q <= crc_step(crc_q, (state_q == S_DATA) ? bus.buf_data : 8'h00);
    end

    assign fcs = ~crc_q;
`endif

    always_comb begin
        bus.busy     = 1'b0;
        bus.done     = 1'b0;
        bus.err      = 1'b0;
        bus.tx_en    = 1'b0;
        bus.txd      = 8'h00;
        bus.buf_addr = 16'd0;
        case (state_q)
            S_PRE: begin
                bus.busy  = 1'b1;
                bus.tx_en = 1'b1;
                bus.txd   = 8'h55;
            end
            S_SFD: begin
                bus.busy  = 1'b1;
                bus.tx_en = 1'b1;
                bus.txd   = 8'hD5;
            end
            S_DATA: begin
                bus.busy  = 1'b1;
                bus.tx_en = 1'b1;
                bus.txd   = bus.buf_data;
                // Prefetch the next byte, but never step past the last one.
                bus.buf_addr = ((cnt_q + 16'd1) < len_q) ? (cnt_q + 16'd1) : cnt_q;
            end
            S_PAD: begin
                bus.busy  = 1'b1;
                bus.tx_en = 1'b1;
            end
`ifdef ETH_TX_FCS_EN
            S_FCS: begin
                bus.busy  = 1'b1;
                bus.tx_en = 1'b1;
                bus.txd   = fcs[{cnt_q[1:0], 3'b000} +: 8];
            end
`endif
            S_GAP:  bus.busy = 1'b1;
            S_RESP: begin
                bus.done = 1'b1;
                bus.err  = err_q;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_eth_tx_framer.sv
// Randomized bench for eth_tx_framer: a frame-level model (preamble, payload,
// zero pad, table-driven CRC-32) predicts every transmitted byte and timing.
module tb_eth_tx_framer;
  localparam int MTU = 1536;
  localparam int IFG = 12;
`ifdef ETH_TX_FCS_EN
  localparam int F = 4;
`else
  localparam int F = 0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [2:0] dbg_state;
  always #5 clk = ~clk;

  eth_tx_framer_if bus();

  eth_tx_framer #(.MTU(MTU), .IFG(IFG)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus),
    .dbg_state(dbg_state)
  );

  // synchronous-read TX buffer
  logic [7:0] mem [0:MTU-1];
  always @(posedge clk)
    bus.buf_data <= (bus.buf_addr < MTU) ? mem[bus.buf_addr] : 8'hEE;

  int tests = 0;
  int fails = 0;

  // monitor state
  int cyc = 0;
  int en_starts, last_en_cyc, done_cnt, done_cyc, addr_viol;
  bit prev_en = 1'b0;
  bit busy_seen, done_err;
  logic [7:0] cap_q[$];
  logic [7:0] exp_q[$];
  logic [31:0] crc_tab [0:255];
  logic [2:0] idle_code;

  always @(negedge clk) begin
    cyc++;
    if (bus.tx_en === 1'b1) begin
      cap_q.push_back(bus.txd);
      if (!prev_en) en_starts++;
      last_en_cyc = cyc;
    end
    prev_en = (bus.tx_en === 1'b1);
    if (bus.done === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
      done_err = bus.err;
    end
    if (bus.busy === 1'b1) busy_seen = 1'b1;
    if (bus.buf_addr >= MTU) addr_viol++;
  end

  task clear_mon();
    cap_q.delete();
    en_starts = 0;
    done_cnt  = 0;
    busy_seen = 1'b0;
    addr_viol = 0;
    done_err  = 1'b0;
  endtask

  function automatic logic [31:0] crc_over(input int from);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    for (int i = from; i < cap_q.size(); i++)
      c = (c >> 8) ^ crc_tab[c[7:0] ^ cap_q[i]];
    return c;
  endfunction

  task build_expected(input int l);
    logic [31:0] c;
    exp_q.delete();
    repeat (7) exp_q.push_back(8'h55);
    exp_q.push_back(8'hD5);
    for (int i = 0; i < l; i++) exp_q.push_back(mem[i]);
    for (int i = l; i < 60; i++) exp_q.push_back(8'h00);
    c = 32'hFFFFFFFF;
    for (int i = 8; i < exp_q.size(); i++)
      c = (c >> 8) ^ crc_tab[c[7:0] ^ exp_q[i]];
    c = ~c;
    if (F == 4) begin
      exp_q.push_back(c[7:0]);
      exp_q.push_back(c[15:8]);
      exp_q.push_back(c[23:16]);
      exp_q.push_back(c[31:24]);
    end
  endtask

  // called at negedge+1; start is sampled by the following rising edge
  task send_start(input int l);
    clear_mon();
    bus.start = 1'b1;
    bus.len   = 16'(l);
    @(negedge clk); #1;
    bus.start = 1'b0;
    bus.len   = 16'($urandom);
  endtask

  task wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk); #1;
      if (done_cnt > 0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Launches a frame in the IDLE cycle right after the previous done, so every
  // call also exercises back-to-back acceptance. inject_at>=0 re-pulses start mid-DATA.
  task test_frame(input int l, input string name, input int inject_at);
    bit ok;
    int budget, first_bad, want_len;
    @(negedge clk); #1;
    tests++;
    if (bus.busy !== 1'b0 || bus.tx_en !== 1'b0) begin
      fails++;
      $display("FAIL %s idle: busy=%b tx_en=%b, required 0/0", name, bus.busy, bus.tx_en);
    end
    build_expected(l);
    send_start(l);
    tests++;
    if (bus.tx_en !== 1'b1 || bus.txd !== 8'h55 || bus.busy !== 1'b1) begin
      fails++;
      $display("FAIL %s launch: tx_en=%b txd=%h busy=%b, required 1/55/1", name, bus.tx_en, bus.txd, bus.busy);
    end
    if (inject_at >= 0) begin
      for (int i = 0; i < 4000 && cap_q.size() < 8 + inject_at; i++) begin
        @(negedge clk); #1;
      end
      bus.start = 1'b1;
      bus.len   = 16'($urandom_range(1, 100));
      @(negedge clk); #1;
      bus.start = 1'b0;
    end
    budget = 8 + ((l > 60) ? l : 60) + F + IFG + 20;
    wait_done(budget, ok);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL %s done_timeout: no done within %0d cycles", name, budget);
    end
    want_len = 8 + ((l > 60) ? l : 60) + F;
    tests++;
    first_bad = -1;
    if (cap_q.size() != exp_q.size()) first_bad = 0;
    else
      for (int i = 0; i < exp_q.size(); i++)
        if (first_bad < 0 && cap_q[i] !== exp_q[i]) first_bad = i;
    if (cap_q.size() != want_len || first_bad >= 0) begin
      fails++;
      $display("FAIL %s bytes: got %0d bytes (first diff idx %0d got %h), required %0d bytes", name,
               cap_q.size(), first_bad, (first_bad >= 0 && first_bad < cap_q.size()) ? cap_q[first_bad] : 8'h00,
               want_len);
    end
    tests++;
    if (en_starts != 1) begin
      fails++;
      $display("FAIL %s contiguous: tx_en rose %0d times, required 1", name, en_starts);
    end
    tests++;
    if (done_cyc - last_en_cyc != IFG + 1) begin
      fails++;
      $display("FAIL %s gap: done %0d cycles after last tx_en, required %0d", name, done_cyc - last_en_cyc, IFG + 1);
    end
    tests++;
    if (done_cnt != 1 || done_err !== 1'b0) begin
      fails++;
      $display("FAIL %s done: count=%0d err=%b, required 1/0", name, done_cnt, done_err);
    end
    tests++;
    if (addr_viol != 0) begin
      fails++;
      $display("FAIL %s addr: %0d cycles with buf_addr>=MTU, required 0", name, addr_viol);
    end
  endtask

  task test_reset();
    #1;
    idle_code = dbg_state;
    tests++;
    if (bus.busy !== 1'b0) begin
      fails++;
      $display("FAIL reset busy: got %b required 0", bus.busy);
    end
    tests++;
    if (bus.done !== 1'b0) begin
      fails++;
      $display("FAIL reset done: got %b required 0", bus.done);
    end
    tests++;
    if (bus.err !== 1'b0) begin
      fails++;
      $display("FAIL reset err: got %b required 0", bus.err);
    end
    tests++;
    if (bus.tx_en !== 1'b0) begin
      fails++;
      $display("FAIL reset tx_en: got %b required 0", bus.tx_en);
    end
    tests++;
    if (bus.txd !== 8'h00) begin
      fails++;
      $display("FAIL reset txd: got %h required 00", bus.txd);
    end
    tests++;
    if (bus.buf_addr !== 16'd0) begin
      fails++;
      $display("FAIL reset buf_addr: got %0d required 0", bus.buf_addr);
    end
  endtask

  task test_reject(input int l, input string name);
    @(negedge clk); #1;
    send_start(l);
    tests++;
    if (bus.done !== 1'b1 || bus.err !== 1'b1 || bus.tx_en !== 1'b0) begin
      fails++;
      $display("FAIL %s resp: done=%b err=%b tx_en=%b, required 1/1/0", name, bus.done, bus.err, bus.tx_en);
    end
    @(negedge clk); #1;
    tests++;
    if (busy_seen || cap_q.size() != 0 || done_cnt != 1 || bus.done !== 1'b0) begin
      fails++;
      $display("FAIL %s quiet: busy_seen=%b bytes=%0d dones=%0d done_now=%b, required 0/0/1/0",
               name, busy_seen, cap_q.size(), done_cnt, bus.done);
    end
  endtask

  task test_len14();
    logic [31:0] res;
    for (int i = 0; i < MTU; i++) mem[i] = 8'($urandom);
    test_frame(14, "len14", -1);
`ifdef ETH_TX_FCS_EN
    res = crc_over(8);
    tests++;
    if (res !== 32'hDEBB20E3) begin
      fails++;
      $display("FAIL len14 residue: got %h required DEBB20E3", res);
    end
`else
    res = crc_over(8);
    tests++;
    if (cap_q.size() != 68 || cap_q[22] !== 8'h00 || cap_q[21] !== mem[13]) begin
      fails++;
      $display("FAIL len14 pad: bytes=%0d residue %h", cap_q.size(), res);
    end
`endif
  endtask

  task test_back_to_back();
    for (int i = 0; i < MTU; i++) mem[i] = 8'($urandom);
    test_frame(40, "restart_ignored", 5);
    test_frame(30, "back_to_back", -1);
  endtask

  task test_reset_mid();
    for (int i = 0; i < MTU; i++) mem[i] = 8'($urandom);
    @(negedge clk); #1;
    send_start(100);
    for (int i = 0; i < 400 && cap_q.size() < 8 + 21; i++) begin
      @(negedge clk); #1;
    end
    rst_n = 1'b0;
    #1;
    tests++;
    if (bus.tx_en !== 1'b0 || bus.busy !== 1'b0 || dbg_state !== idle_code) begin
      fails++;
      $display("FAIL reset_mid abort: tx_en=%b busy=%b state=%0d, required 0/0/%0d", bus.tx_en, bus.busy, dbg_state, idle_code);
    end
    @(negedge clk); #1;
    clear_mon();
    rst_n = 1'b1;
    repeat (150) @(negedge clk);
    #1;
    tests++;
    if (done_cnt != 0 || cap_q.size() != 0) begin
      fails++;
      $display("FAIL reset_mid quiet: dones=%0d bytes=%0d, required 0/0", done_cnt, cap_q.size());
    end
    test_frame(60, "after_reset_len60", -1);
  endtask

  task test_random();
    repeat (6) begin
      for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
      test_frame($urandom_range(1, 200), "random", -1);
    end
  endtask

  initial begin
    logic [31:0] c;
    for (int n = 0; n < 256; n++) begin
      c = 32'(n);
      repeat (8) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
      crc_tab[n] = c;
    end
    for (int i = 0; i < MTU; i++) mem[i] = 8'(i);
    bus.start = 1'b0;
    bus.len   = 16'd0;
    clear_mon();
    repeat (3) @(negedge clk);
    test_reset();
    rst_n = 1'b1;

    test_frame(64, "len64", -1);
    test_len14();
    test_reject(0, "reject_len0");
    test_reject(MTU + 1, "reject_over_mtu");
    test_back_to_back();
    test_reset_mid();
    for (int i = 0; i < MTU; i++) mem[i] = 8'($urandom);
    test_frame(60, "len60", -1);
    test_frame(MTU, "len_mtu", -1);
    test_random();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
